cia_timer_bank: RTL and testbench
=================================

# cia_timer_bank

Parametrised bank of cascadable down-counting interval timers, the generalised successor of the fixed pair of 16-bit CIA timers. It provides NUM_TIMERS channels of WIDTH bits, each with its own latch, control register, input-source select, one-shot/continuous mode and pulse/toggle port output. Channel n can count underflows of channel n-1. It sits beside the ports, TOD, serial and interrupt blocks in the CIA core; its `intr` vector feeds interrupt control, and its `pb` vector feeds the port block.

## Interface
- NUM_TIMERS, 2, channel count; legal range 1..8.
- WIDTH, 16, counter/latch width; multiple of 8, range 8..32. BYTES = WIDTH/8.
- clk  in  1  system clock; single clock domain.
- res  in  1  synchronous, active-high reset.
- phi2_dn  in  1  one-clk tick strobe on PHI2 falling edge; all counting is qualified by it.
- cnt_up  in  1  one-clk strobe for a CNT rising edge, aligned to phi2_dn.
- cnt  in  1  CNT pin level, synchronised.
- we  in  1  register write strobe, one clk.
- tsel  in  $clog2(NUM_TIMERS) (min 1)  channel select.
- bsel  in  $clog2(BYTES+1)  byte select. 0..BYTES-1 selects a latch byte, LSB first. BYTES selects the control register.
- data  in  8  write data.
- count_o  out  NUM_TIMERS*WIDTH  live counters, channel 0 in the LSBs.
- ctrl_o  out  NUM_TIMERS*8  control registers as read back. The force-load bit always reads 0.
- ufl  out  NUM_TIMERS  underflow strobe, one clk.
- intr  out  NUM_TIMERS  interrupt source strobe; equal to ufl.
- pb  out  NUM_TIMERS  port output level, valid when pbon=1.
- pbon  out  NUM_TIMERS  port-override enables (ctrl bit 1).

## Operation
- Control byte layout:
  - bit0 start
  - bit1 pbon
  - bit2 outmode (0 pulse, 1 toggle)
  - bit3 runmode (0 continuous, 1 one-shot)
  - bit4 force load (strobe, not stored)
  - bits6:5 inmode: 0 = tick, 1 = cnt_up, 2 = ufl[n-1], 3 = ufl[n-1] & cnt
  - bit7 stored, no function.
- Channel 0 with inmode 2 or 3 never counts.
- Count enable for a channel = phi2_dn & start & source(inmode).
- On an enabled tick:
  - If counter == 0: reload from latch, assert ufl for that clk. If runmode=1, clear start.
  - Otherwise decrement by 1.
- Cascade is combinational: ufl[n-1] and the reload/decrement of channel n happen in the same clk. A full ripple across all channels completes in one tick.
- Latch byte write: updates that byte only. If the top byte (bsel = BYTES-1) is written while start=0, the counter also loads from the new full latch value.
- Force load: counter loads from the latch on that clk, regardless of start.
- pb behaviour:
  - Pulse mode: pb = 1 from the underflow clk until the next phi2_dn.
  - Toggle mode: pb inverts on each underflow. A control write that changes start from 0 to 1 sets pb = 1.

## Timing
- Reset values: counters and latches all ones (2^WIDTH-1), ctrl 0, ufl/intr 0, pb 0, pbon 0.
- Register writes take effect the clk after `we`. `count_o` and `ctrl_o` are registered and reflect the write one clk later.
- ufl and intr are asserted in the clk where the counter reaches its reload point.
- Underflow-to-reloaded-counter latency is 0 ticks: the counter shows the latch value in the next clk.
- Simultaneous events:
  - Control write + enabled tick in the same clk: the count uses the old start/inmode; the written value wins for ctrl. A one-shot clear of start is overridden by a write with start=1.
  - Force load + enabled tick: load wins, no decrement, no ufl.
  - Latch write + underflow: reload uses the pre-write latch value; the new value applies to later reloads.
  - Top-byte write while stopped + force load: the new latch value is loaded.
- res asserted mid-count: all state returns to reset values on that clk. Strobes drop immediately.
- WIDTH wrap: counter never goes below 0. Latch 0 gives an underflow on every enabled tick.

## Structure
- Package `cia`:
  - `tinmode_t` enum (TICK, CNT, CASCADE, CASCADE_CNT)
  - `tctrl_reg_t` packed struct for the control byte
  - localparams for the control bit positions.
- Sub-module `cia_timer_chan`:
  - One channel per instance, parametrised by WIDTH.
  - Inputs: tick enable, source, write strobes.
  - Outputs: counter, ufl, pb.
- `cia_timer_bank` generates NUM_TIMERS instances and chains ufl[n-1] into each.

## Test plan
- Reset, WIDTH=16: count_o = 0xFFFF per channel, ctrl_o = 0, pb = 0, ufl = 0 -> all hold for 10 ticks.
- Latch = 0x0003, ctrl = 0x01: counter runs 3,2,1,0, then reloads 3 with ufl on the 4th enabled tick. Period is 4 ticks, repeating.
- One-shot with toggle (latch 2, ctrl 0x0F): pb = 1 at start; one ufl after 3 ticks; pb = 0; start reads 0; counting stops.
- Cascade, NUM_TIMERS=3, WIDTH=8: ch0 latch 1 with inmode 0, ch1 latch 1 with inmode 2, ch2 latch 0 with inmode 2 -> ch2 ufl every 4 ticks, coincident in the same clk with ch1 and ch0 ufl.
- Force load + tick in the same clk with counter 5 and latch 9 -> counter = 9, ufl = 0. Also a latch write coinciding with underflow -> reload uses the old latch.
- res asserted mid-count with counter 0x1234 -> next clk all reset values; no stray ufl afterwards.

Source files
------------

// File: rtl/cia_pkg.sv
// Shared definitions for the CIA timer bank.
//   tinmode_t    - count source selection for a timer channel
//   tctrl_reg_t  - layout of the per-channel control byte
//   CTRL_*       - bit positions inside the control byte
package cia;

  typedef enum logic [1:0] {
    TICK        = 2'd0,  // every phi2_dn
    CNT         = 2'd1,  // CNT rising edges
    CASCADE     = 2'd2,  // underflows of the previous channel
    CASCADE_CNT = 2'd3   // previous-channel underflows while CNT is high
  } tinmode_t;

  typedef struct packed {
    logic     spare;       // bit7: stored, no function
    tinmode_t inmode;      // bits6:5
    logic     force_load;  // bit4: write-only strobe
    logic     runmode;     // bit3: 1 = one-shot
    logic     outmode;     // bit2: 1 = toggle
    logic     pbon;        // bit1
    logic     start;       // bit0
  } tctrl_reg_t;

  localparam int CTRL_START   = 0;
  localparam int CTRL_PBON    = 1;
  localparam int CTRL_OUTMODE = 2;
  localparam int CTRL_RUNMODE = 3;
  localparam int CTRL_FORCE   = 4;
  localparam int CTRL_INMODE  = 5;

endpackage

// File: rtl/cia_timer_chan.sv
// One down-counting interval timer channel.
//   clk, res        clock, synchronous active-high reset
//   tick            phi2_dn qualifier for all counting
//   cnt_up, cnt     CNT rising-edge strobe and CNT level
//   casc_ufl        underflow of the previous channel (0 for channel 0)
//   latch_we        latch byte write, byte chosen by bsel
//   ctrl_we         control register write
//   data            write data
//   count           live counter
//   ctrl            control register as read back (force-load reads 0)
//   ufl             underflow strobe, combinational so cascades ripple in one clk
//   pb              port output level
module cia_timer_chan
  import cia::*;
#(
  parameter int WIDTH  = 16,
  parameter int BSEL_W = $clog2(WIDTH / 8 + 1)
) (
  input  logic              clk,
  input  logic              res,
  input  logic              tick,
  input  logic              cnt_up,
  input  logic              cnt,
  input  logic              casc_ufl,
  input  logic              latch_we,
  input  logic              ctrl_we,
  input  logic [BSEL_W-1:0] bsel,
  input  logic [7:0]        data,
  output logic [WIDTH-1:0]  count,
  output logic [7:0]        ctrl,
  output logic              ufl,
  output logic              pb
);

  localparam int BYTES = WIDTH / 8;

  tctrl_reg_t       ctrl_q;
  tctrl_reg_t       wr_ctrl;
  logic [WIDTH-1:0] latch_q;
  logic [WIDTH-1:0] latch_d;
  logic [WIDTH-1:0] count_q;
  logic             src;
  logic             en;
  logic             force_ld;
  logic             top_wr;
  logic             load_now;
  logic             start_rise;

  always_comb begin
    wr_ctrl = tctrl_reg_t'(data);
    // The stored copy never keeps the force-load strobe.
    wr_ctrl.force_load = 1'b0;

    src = 1'b0;
    case (ctrl_q.inmode)
      TICK:        src = 1'b1;
      CNT:         src = cnt_up;
      CASCADE:     src = casc_ufl;
      CASCADE_CNT: src = casc_ufl & cnt;
      default:     src = 1'b0;
    endcase

    force_ld = ctrl_we & data[CTRL_FORCE];
    // Counting uses the control value registered before any same-clk write.
    en       = tick & ctrl_q.start & src & ~res;
    // A force load pre-empts the tick, so no underflow is reported with it.
    ufl      = en & (count_q == '0) & ~force_ld;

    top_wr   = latch_we && (bsel == BSEL_W'(BYTES - 1));
    load_now = force_ld | (top_wr & ~ctrl_q.start);

    latch_d = latch_q;
    for (int i = 0; i < BYTES; i++) begin
      if (latch_we && (bsel == BSEL_W'(i))) latch_d[8*i +: 8] = data;
    end

    start_rise = ctrl_we & wr_ctrl.start & ~ctrl_q.start & wr_ctrl.outmode;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      count_q <= '1;
      latch_q <= '1;
      ctrl_q  <= '0;
      pb      <= 1'b0;
    end else begin
      latch_q <= latch_d;

      // Loads see the new latch; underflow reloads see the pre-write latch.
      if (load_now)  count_q <= latch_d;
      else if (ufl)  count_q <= latch_q;
      else if (en)   count_q <= count_q - WIDTH'(1);

      // A control write overrides the one-shot clear of start.
      if (ctrl_we)                      ctrl_q       <= wr_ctrl;
      else if (ufl && ctrl_q.runmode)   ctrl_q.start <= 1'b0;

      if (start_rise) begin
        pb <= 1'b1;
      end else if (ctrl_q.outmode) begin
        if (ufl) pb <= ~pb;
      end else begin
        // Pulse: high from the underflow until the next phi2_dn.
        if (ufl)       pb <= 1'b1;
        else if (tick) pb <= 1'b0;
      end
    end
  end

  assign count = count_q;
  assign ctrl  = ctrl_q;

endmodule

// File: rtl/cia_timer_bank.sv
// Bank of NUM_TIMERS cascadable CIA-style interval timers.
//   clk, res        clock, synchronous active-high reset
//   phi2_dn         tick strobe qualifying all counting
//   cnt_up, cnt     CNT rising-edge strobe and synchronised level
//   we, tsel, bsel  register write strobe, channel and byte select
//                   (bsel < BYTES: latch byte LSB first, bsel == BYTES: control)
//   data            write data
//   count_o         live counters, channel 0 in the LSBs
//   ctrl_o          control registers, channel 0 in the LSBs
//   ufl, intr       underflow strobes (intr is the interrupt-source copy)
//   pb, pbon        port output levels and their override enables
module cia_timer_bank
  import cia::*;
#(
  parameter int  NUM_TIMERS = 2,
  parameter int  WIDTH      = 16,
  localparam int BYTES      = WIDTH / 8,
  localparam int TSEL_W     = (NUM_TIMERS > 1) ? $clog2(NUM_TIMERS) : 1,
  localparam int BSEL_W     = $clog2(BYTES + 1)
) (
  input  logic                        clk,
  input  logic                        res,
  input  logic                        phi2_dn,
  input  logic                        cnt_up,
  input  logic                        cnt,
  input  logic                        we,
  input  logic [TSEL_W-1:0]           tsel,
  input  logic [BSEL_W-1:0]           bsel,
  input  logic [7:0]                  data,
  output logic [NUM_TIMERS*WIDTH-1:0] count_o,
  output logic [NUM_TIMERS*8-1:0]     ctrl_o,
  output logic [NUM_TIMERS-1:0]       ufl,
  output logic [NUM_TIMERS-1:0]       intr,
  output logic [NUM_TIMERS-1:0]       pb,
  output logic [NUM_TIMERS-1:0]       pbon
);

  // chain[n] is the cascade source of channel n; channel 0 has none.
  logic [NUM_TIMERS:0] chain;
  assign chain[0] = 1'b0;

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
    logic sel;
    logic latch_we;
    logic ctrl_we;

    assign sel      = we && (tsel == TSEL_W'(n));
    assign latch_we = sel && (bsel < BSEL_W'(BYTES));
    assign ctrl_we  = sel && (bsel == BSEL_W'(BYTES));

    cia_timer_chan #(
      .WIDTH  (WIDTH),
      .BSEL_W (BSEL_W)
    ) u_chan (
      .clk      (clk),
      .res      (res),
      .tick     (phi2_dn),
      .cnt_up   (cnt_up),
      .cnt      (cnt),
      .casc_ufl (chain[n]),
      .latch_we (latch_we),
      .ctrl_we  (ctrl_we),
      .bsel     (bsel),
      .data     (data),
      .count    (count_o[n*WIDTH +: WIDTH]),
      .ctrl     (ctrl_o[n*8 +: 8]),
      .ufl      (ufl[n]),
      .pb       (pb[n])
    );

    assign chain[n+1] = ufl[n];
    assign pbon[n]    = ctrl_o[n*8 + CTRL_PBON];
  end

  assign intr = ufl;

endmodule

// File: tb/tb_cia_timer_bank.sv
module tb_cia_timer_bank;

  localparam int NT = 3;
  localparam int W  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           res = 1'b1;
  logic           phi2_dn = 1'b0;
  logic           cnt_up = 1'b0;
  logic           cnt = 1'b0;
  logic           we = 1'b0;
  logic [1:0]     tsel = '0;
  logic [1:0]     bsel = '0;
  logic [7:0]     data = '0;
  logic [NT*W-1:0] count_o;
  logic [NT*8-1:0] ctrl_o;
  logic [NT-1:0]  ufl, intr, pb, pbon;

  cia_timer_bank #(.NUM_TIMERS(NT), .WIDTH(W)) dut (
    .clk(clk), .res(res), .phi2_dn(phi2_dn), .cnt_up(cnt_up), .cnt(cnt),
    .we(we), .tsel(tsel), .bsel(bsel), .data(data),
    .count_o(count_o), .ctrl_o(ctrl_o), .ufl(ufl), .intr(intr),
    .pb(pb), .pbon(pbon)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wr(input int t, input int b, input logic [7:0] d);
    @(negedge clk);
    we = 1'b1; tsel = 2'(t); bsel = 2'(b); data = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_tick(output logic [NT-1:0] u, output logic [NT-1:0] ir);
    @(negedge clk);
    phi2_dn = 1'b1;
    #1 u = ufl; ir = intr;
    @(negedge clk);
    phi2_dn = 1'b0;
  endtask

  task automatic tick_wr(input int t, input int b, input logic [7:0] d, output logic [NT-1:0] u);
    @(negedge clk);
    phi2_dn = 1'b1; we = 1'b1; tsel = 2'(t); bsel = 2'(b); data = d;
    #1 u = ufl;
    @(negedge clk);
    phi2_dn = 1'b0; we = 1'b0;
  endtask

  logic [NT-1:0] u, ir, seen;
  logic [2:0] casc_exp [8] = '{3'd0, 3'd1, 3'd0, 3'd7, 3'd0, 3'd1, 3'd0, 3'd7};

  initial begin
    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk) res = 1'b0;
    check("rst_count", count_o, {NT{16'hFFFF}});
    check("rst_ctrl", ctrl_o, 0);
    check("rst_pb", pb, 0);
    check("rst_pbon", pbon, 0);
    seen = '0;
    for (int k = 0; k < 10; k++) begin
      do_tick(u, ir);
      seen |= u;
    end
    check("rst_idle_ufl", seen, 0);
    check("rst_idle_count", count_o, {NT{16'hFFFF}});

    // Continuous, latch 3, tick source
    wr(0, 0, 8'h03);
    wr(0, 1, 8'h00);
    check("ch0_load", count_o[15:0], 16'd3);
    wr(0, 2, 8'h01);
    check("ch0_ctrl", ctrl_o[7:0], 8'h01);
    exp_q = '{16'd2, 16'd1, 16'd0, 16'd3, 16'd2, 16'd1, 16'd0, 16'd3};
    for (int k = 0; k < 8; k++) begin
      do_tick(u, ir);
      check("ch0_ufl", u[0], (k % 4 == 3));
      check("ch0_count", count_o[15:0], exp_q.pop_front());
    end
    wr(0, 2, 8'h00);

    // One-shot, toggle, pbon on channel 1
    wr(1, 0, 8'h02);
    wr(1, 1, 8'h00);
    check("ch1_load", count_o[31:16], 16'd2);
    wr(1, 2, 8'h0F);
    check("os_pb_start", pb[1], 1'b1);
    check("os_pbon", pbon[1], 1'b1);
    exp_q = '{16'd1, 16'd0, 16'd2};
    for (int k = 0; k < 3; k++) begin
      do_tick(u, ir);
      check("os_ufl", u[1], (k == 2));
      check("os_count", count_o[31:16], exp_q.pop_front());
    end
    check("os_pb_after", pb[1], 1'b0);
    check("os_ctrl", ctrl_o[15:8], 8'h0E);
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      do_tick(u, ir);
      seen |= u;
    end
    check("os_stopped_ufl", seen, 0);
    check("os_stopped_count", count_o[31:16], 16'd2);

    // Cascade: ch0 latch 1, ch1 latch 1 cascade, ch2 latch 0 cascade
    wr(0, 0, 8'h01); wr(0, 1, 8'h00);
    wr(1, 0, 8'h01); wr(1, 1, 8'h00);
    wr(2, 0, 8'h00); wr(2, 1, 8'h00);
    wr(2, 2, 8'h41);
    wr(1, 2, 8'h41);
    wr(0, 2, 8'h01);
    for (int k = 0; k < 8; k++) begin
      do_tick(u, ir);
      check("casc_ufl", u, casc_exp[k]);
      check("casc_intr", ir, casc_exp[k]);
      check("casc_pb0", pb[0], casc_exp[k][0]);
    end
    wr(0, 2, 8'h00); wr(1, 2, 8'h00); wr(2, 2, 8'h00);

    // Force load coinciding with an enabled tick
    wr(0, 0, 8'h05); wr(0, 1, 8'h00);
    wr(0, 0, 8'h09);
    check("fl_pre_count", count_o[15:0], 16'd5);
    wr(0, 2, 8'h01);
    tick_wr(0, 2, 8'h11, u);
    check("fl_ufl", u[0], 1'b0);
    check("fl_count", count_o[15:0], 16'd9);
    check("fl_ctrl", ctrl_o[7:0], 8'h01);

    // Latch write coinciding with an underflow; latch 0 underflows every tick
    wr(0, 2, 8'h00);
    wr(0, 0, 8'h00); wr(0, 1, 8'h00);
    check("lw_pre_count", count_o[15:0], 16'd0);
    wr(0, 2, 8'h01);
    tick_wr(0, 0, 8'h07, u);
    check("lw_ufl", u[0], 1'b1);
    check("lw_old_reload", count_o[15:0], 16'd0);
    do_tick(u, ir);
    check("lw_ufl2", u[0], 1'b1);
    check("lw_new_reload", count_o[15:0], 16'd7);
    do_tick(u, ir);
    check("lw_dec", count_o[15:0], 16'd6);

    // Reset mid-count
    wr(0, 2, 8'h00);
    wr(0, 0, 8'h34); wr(0, 1, 8'h12);
    check("mr_count", count_o[15:0], 16'h1234);
    wr(0, 2, 8'h01);
    @(negedge clk);
    res = 1'b1; phi2_dn = 1'b1;
    #1 check("mr_ufl_in_reset", ufl, 0);
    @(negedge clk);
    res = 1'b0; phi2_dn = 1'b0;
    check("mr_count_rst", count_o, {NT{16'hFFFF}});
    check("mr_ctrl_rst", ctrl_o, 0);
    check("mr_pb_rst", pb, 0);
    seen = '0;
    for (int k = 0; k < 5; k++) begin
      do_tick(u, ir);
      seen |= u;
    end
    check("mr_no_ufl", seen, 0);
    check("mr_count_hold", count_o, {NT{16'hFFFF}});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
